mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Multi-cycle sequencer for the RV32M multiply/divide operations in the EX stage of the RV32IM pipeline. It replaces single-cycle combinational `*`, `/` and `%` paths with:
- an iterative radix-2 shift-add multiplier;
- a restoring divider.

It accepts one operation at a time, holds `BUSY` high so the hazard unit stalls IF/ID/EX, and returns a registered 32-bit result with a one-cycle `VALID` strobe. The EX-stage mux selects `RESULT` whenever the ALU select code is `6'b001xxx`.

## Interface
- `XLEN`, 32: operand and result width. Only 32 is supported.
- `CLK`  in  1  rising-edge clock.
- `RESET`  in  1  synchronous, active-high reset.
- `START`  in  1  launch request. Sampled only in `IDLE`.
- `SELECT`  in  3  RV32M funct3:
  - `000` MUL, `001` MULH, `010` MULHSU, `011` MULHU;
  - `100` DIV, `101` DIVU, `110` REM, `111` REMU.
- `DATA1`  in  32  rs1 operand (multiplicand/dividend). Captured on `START`.
- `DATA2`  in  32  rs2 operand (multiplier/divisor). Captured on `START`.
- `FLUSH`  in  1  abort the in-flight operation (branch mispredict or trap).
- `BUSY`  out  1  operation in progress. Used as the pipeline stall.
- `VALID`  out  1  one-cycle strobe: `RESULT` is ready.
- `RESULT`  out  32  final result. Held until the next accepted `START`.

## Operation
- **States:** `IDLE`, `CALC`, `FIX`, `DONE`.
- **IDLE:**
  - On `START=1`, latch the operands and `SELECT`.
  - Signed ops (MULH, DIV, REM; MULHSU for `DATA1` only) convert operands to magnitudes and record the result sign. Unsigned ops do not.
  - Load a 6-bit iteration counter with 0, then go to `CALC`.
- **CALC, multiply:** each cycle, conditionally add the multiplicand into the upper half of a 64-bit accumulator, then shift right one bit.
- **CALC, divide:** each cycle, shift the remainder left with the next dividend bit, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
- **CALC exit:** the counter increments each cycle. After the iteration with counter=31, go to `FIX`.
- **FIX:**
  - Negate the result if the recorded sign is set.
  - Quotient sign is `DATA1[31]^DATA2[31]`; remainder sign follows the dividend.
  - Select the low word (MUL), high word (MULH/MULHSU/MULHU), quotient or remainder.
  - Go to `DONE`.
- **DONE:** `VALID=1` for one cycle, then return to `IDLE`.
- **Special cases**, detected in `IDLE` at `START`: go directly to `DONE` with no `CALC`.
  - Divide by zero: DIV/DIVU give `32'hFFFFFFFF`; REM/REMU give `DATA1`.
  - Signed overflow (DIV with `DATA1=32'h80000000`, `DATA2=32'hFFFFFFFF`): DIV gives `32'h80000000`; REM gives 0.
  - Multiply where either operand is 0: `RESULT=0`.
- **BUSY** = state != `IDLE`. It includes the `DONE` cycle, so the stall releases together with `VALID`.
- **START while BUSY:** ignored. The pipeline cannot issue it, because it is stalled.
- **FLUSH:** in any non-`IDLE` state, go to `IDLE` next cycle. No `VALID` is produced and `RESULT` is unchanged. If `START` and `FLUSH` are both asserted in `IDLE`, `FLUSH` wins and `START` is dropped.
- **RESET:** works at any time, including mid-operation. Next state is `IDLE`; all internal registers are cleared.

## Timing
- **Reset values:** `BUSY=0`, `VALID=0`, `RESULT=32'h0`, state `IDLE`, counter 0.
- **Cycle numbering:** cycle 0 is the rising edge that samples `START`.
- **Iterative op:**
  - `BUSY=1` from cycle 1.
  - `CALC` occupies cycles 1–32, `FIX` is cycle 33, `DONE` is cycle 34.
  - `VALID=1` and `BUSY=1` in cycle 34; `BUSY=0` from cycle 35.
  - Latency is 34 cycles.
- **Special-case op:** `DONE` in cycle 1 (`VALID=1`), `IDLE` in cycle 2. Latency is 1.
- **Back-to-back:** the next `START` is accepted in the cycle after `DONE`.
- **RESULT update:** `RESULT` is registered and changes only on entry to `DONE`.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - All four multiply ops use a single 64-bit signed×signed product on sign/zero-extended 33-bit operands.
  - They go `IDLE`→`DONE` with latency 1. `CALC`/`FIX` are used only by divides.
- `MDU_FAST_MUL_EN` undefined: multiplies use the iterative path, with latency 34. Divide behaviour is identical in both builds.

## Test plan
- **MUL, iterative:** `DATA1=7`, `DATA2=-3` (`32'hFFFFFFFD`) → `RESULT=32'hFFFFFFEB`, `VALID` in cycle 34, `BUSY` in cycles 1–34. With `MDU_FAST_MUL_EN`: same result, `VALID` in cycle 1.
- **MULH / MULHU / MULHSU:** `DATA1=DATA2=32'h80000000` → `32'h40000000`, `32'h40000000`, `32'hC0000000` respectively.
- **DIV and REM:** DIV `-7/2` → `32'hFFFFFFFD`; REM `-7,2` → `32'hFFFFFFFF`; DIVU `32'hFFFFFFFF/16` → `32'h0FFFFFFF`.
- **Special cases:** DIVU x/0 → `32'hFFFFFFFF` and REMU x/0 → `x`, both with latency 1. DIV `32'h80000000/-1` → `32'h80000000`; REM of the same operands → 0.
- **FLUSH mid-CALC:** `FLUSH` at cycle 10 → `IDLE` at cycle 11, no `VALID`, `RESULT` keeps its prior value. A new `START` at cycle 11 completes normally.
- **RESET mid-op and collisions:**
  - `RESET` at cycle 5 → all outputs are at reset values at cycle 6.
  - `START` during `BUSY` is ignored.
  - `START`+`FLUSH` together in `IDLE` → no operation.

Source files
------------

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV32M multiply/restoring-divide sequencer; define MDU_FAST_MUL_EN for single-cycle multiplies
module mdu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            VALID,
  output logic [XLEN-1:0] RESULT
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  state_t state, state_n;
  logic [2:0] op;
  logic [2*XLEN-1:0] acc, mul_next, div_next, prod;
  logic [XLEN-1:0] mcand, a_mag, b_mag, quo, rem, div_diff, quick_res, spec_res, fix_res;
  logic [XLEN:0] mul_sum;
  logic [5:0] cnt;
  logic neg_q, neg_r, a_sgn, b_sgn, div_zero, ovf, quick, special, accept, div_ge;
  assign a_sgn = (SELECT == 3'b001 || SELECT == 3'b010 || SELECT == 3'b100 || SELECT == 3'b110) && DATA1[XLEN-1];
  assign b_sgn = (SELECT == 3'b001 || SELECT == 3'b100 || SELECT == 3'b110) && DATA2[XLEN-1];
  assign a_mag = a_sgn ? -DATA1 : DATA1;
  assign b_mag = b_sgn ? -DATA2 : DATA2;
  assign div_zero = SELECT[2] && DATA2 == '0;
  assign ovf = (SELECT == 3'b100 || SELECT == 3'b110) && DATA1 == MIN_NEG && DATA2 == ALL_ONES;
`ifdef MDU_FAST_MUL_EN
  logic signed [2*XLEN-1:0] a_ext, b_ext, fprod;
  assign a_ext = {{XLEN{a_sgn}}, DATA1};
  assign b_ext = {{XLEN{SELECT == 3'b001 && DATA2[XLEN-1]}}, DATA2};
  assign fprod = a_ext * b_ext;
  assign quick = !SELECT[2];
  assign quick_res = SELECT == 3'b000 ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`else
  assign quick = !SELECT[2] && (DATA1 == '0 || DATA2 == '0);
  assign quick_res = '0;
`endif
  assign special = quick || div_zero || ovf;
  assign spec_res = div_zero ? (SELECT[1] ? DATA1 : ALL_ONES) : ovf ? (SELECT[1] ? '0 : MIN_NEG) : quick_res;
  assign accept = state == IDLE && START && !FLUSH;
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};
  assign div_ge = acc[2*XLEN-1:XLEN-1] >= {1'b0, mcand};
  assign div_diff = acc[2*XLEN-2:XLEN-1] - mcand;
  assign div_next = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
  assign prod = neg_q ? -acc : acc;
  assign quo = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign fix_res = op[2] ? (op[1] ? rem : quo) : (op == 3'b000 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  assign BUSY = state != IDLE;
  assign VALID = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? (special ? DONE : CALC) : IDLE;
      CALC: state_n = FLUSH ? IDLE : (cnt == 6'(XLEN-1) ? FIX : CALC);
      FIX:  state_n = FLUSH ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      op <= '0;
      acc <= '0;
      mcand <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      RESULT <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op <= SELECT;
        acc <= {{XLEN{1'b0}}, SELECT[2] ? a_mag : b_mag};
        mcand <= SELECT[2] ? b_mag : a_mag;
        cnt <= '0;
        neg_q <= a_sgn ^ b_sgn;
        neg_r <= a_sgn;
        if (special) RESULT <= spec_res;
      end
      if (state == CALC) begin
        acc <= op[2] ? div_next : mul_next;
        cnt <= cnt + 6'd1;
      end
      if (state == FIX && !FLUSH) RESULT <= fix_res;
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed self-checking bench for mdu_sequencer
module tb_mdu_sequencer;
  logic clk, rst, start, flush, busy, valid;
  logic [2:0] sel;
  logic [31:0] d1, d2, result, last;
  int checks, errors;
  logic seen_valid;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  mdu_sequencer #(.XLEN(32)) dut (
    .CLK(clk), .RESET(rst), .START(start), .SELECT(sel), .DATA1(d1), .DATA2(d2),
    .FLUSH(flush), .BUSY(busy), .VALID(valid), .RESULT(result)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [2:0] s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input int poke);
    int lat;
    logic busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    sel = s;
    d1 = a;
    d2 = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (!busy) busy_ok = 1'b0;
      if (valid) begin
        lat = n;
        break;
      end
      start = (n == poke);
      if (n == poke) d1 = ~d1;
      @(negedge clk);
      start = 1'b0;
    end
    check({tag, " lat"}, 64'(lat), 64'(exp_lat));
    check({tag, " res"}, {32'h0, result}, {32'h0, exp});
    check({tag, " busy"}, {63'h0, busy_ok}, 64'h1);
    @(negedge clk);
    check({tag, " idle"}, {62'h0, busy, valid}, 64'h0);
    last = exp;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    sel = '0;
    d1 = '0;
    d2 = '0;
    last = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset", {31'h0, busy, valid, result}, 64'h0);
    run_op("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, 0);
    run_op("mulh", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, 0);
    run_op("mulhu", 3'b011, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, 0);
    run_op("mulhsu", 3'b010, 32'h80000000, 32'h80000000, 32'hC0000000, MUL_LAT, 0);
    run_op("mulh_neg", 3'b001, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, MUL_LAT, 0);
    run_op("mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, 0);
    run_op("mul_zero", 3'b000, 32'd0, 32'd5, 32'h0, 1, 0);
    run_op("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 0);
    run_op("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 0);
    run_op("div_negb", 3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34, 0);
    run_op("rem_negb", 3'b110, 32'd7, 32'hFFFFFFFE, 32'h1, 34, 0);
    run_op("divu", 3'b101, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 34, 0);
    run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34, 0);
    run_op("divu_z", 3'b101, 32'h12345678, 32'd0, 32'hFFFFFFFF, 1, 0);
    run_op("remu_z", 3'b111, 32'h12345678, 32'd0, 32'h12345678, 1, 0);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 0);
    run_op("start_busy", 3'b101, 32'd1000, 32'd7, 32'd142, 34, 5);
    sel = 3'b101;
    d1 = 32'd100;
    d2 = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_valid = 1'b0;
    repeat (9) begin
      seen_valid |= valid;
      @(negedge clk);
    end
    seen_valid |= valid;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush", {30'h0, seen_valid, busy, valid, result}, {32'h0, last});
    run_op("after_flush", 3'b111, 32'd100, 32'd7, 32'd2, 34, 0);
    sel = 3'b101;
    d1 = 32'd9;
    d2 = 32'd0;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("start_flush", {31'h0, busy, valid, result}, {32'h0, last});
    @(negedge clk);
    check("start_flush2", {62'h0, busy, valid}, 64'h0);
    sel = 3'b100;
    d1 = 32'd50;
    d2 = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_mid", {31'h0, busy, valid, result}, 64'h0);
    run_op("post_reset", 3'b000, 32'd6, 32'd7, 32'd42, MUL_LAT, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
